load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit between the execute stage and the unified memory bus. Accepts one RV32I load or store request per transaction over a valid/ready handshake and converts it into word-aligned bus cycles with byte enables and replicated store data. For loads it captures the bus read data, then extracts and sign- or zero-extends it. Misaligned or illegal requests are reported without any bus access.

## Interface
Parameters:
- WIDTH, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, right-aligned
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  WIDTH  extended load data; 0 for stores and faults
- resp_misaligned  out  1  address not aligned to the access size
- resp_illegal  out  1  funct3 invalid for the direction
- mem_read  out  1  to bus mem_read
- mem_write  out  1  to bus mem_write
- mem_addr  out  WIDTH  word-aligned address, bits [1:0] = 0
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_byteen  out  4  byte lane enables
- mem_rdata  in  WIDTH  bus read data, valid one cycle after mem_read rises

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/funct3/addr/wdata.
  - Check legality:
    - Loads allow 000, 001, 010, 100, 101.
    - Stores allow 000, 001, 010.
  - Check alignment: H needs addr[0] = 0; W needs addr[1:0] = 0.
  - If either check fails, go to RESP with the matching flag set. Illegal takes precedence over misaligned; only one flag is set.
  - Otherwise go to ACCESS.
- ACCESS:
  - Store: mem_write = 1 for exactly this cycle, then go to RESP.
  - Load: mem_read = 1, then go to WAIT.
- WAIT (loads only):
  - mem_read stays 1.
  - Capture mem_rdata at the end of the cycle, then go to RESP.
- RESP:
  - resp_valid = 1; all response outputs are stable.
  - On resp_ready, go to IDLE. A new request can be accepted no earlier than the following cycle.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 for addr[1] = 0, 4'b1100 for addr[1] = 1.
  - W: 4'b1111.
- Store data replication:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata unchanged.
- Load extraction:
  - Select the byte lane addr[1:0] or the half lane addr[1].
  - Sign-extend for 000/001; zero-extend for 100/101.
- Bus outputs:
  - mem_addr, mem_wdata and mem_byteen are driven from registered request fields during ACCESS and WAIT.
  - They are 0 in IDLE and RESP.
  - Faulted requests never assert mem_read or mem_write.
- Region decoding belongs to the bus. A store outside data memory completes normally with no flag.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_* 0, mem_read 0, mem_write 0, mem_addr/mem_wdata/mem_byteen 0.
- Reset is asynchronous. Asserting rst in any state drops mem_write and mem_read immediately, and the interrupted transaction produces no response.
- Latency from the accept edge (cycle 0) to resp_valid:
  - Faulted request: cycle 1.
  - Store: cycle 2.
  - Load: cycle 3.
- resp_valid held with resp_ready = 0: the unit stays in RESP indefinitely with the outputs unchanged.
- req_valid during ACCESS/WAIT/RESP is ignored because req_ready = 0. The requester must hold the request until it is accepted.

## Structure
- defs.svh additions:
  - funct3 encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - State encoding typedef lsu_state_t.
- Sub-module lsu_align (combinational):
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: byteen, replicated wdata, extended rdata, misaligned, illegal.
- load_store_unit holds the FSM, the request registers and the load data register.

## Test plan
- SW addr 0x1004, wdata 0xDEADBEEF -> ACCESS cycle shows mem_write = 1, mem_addr 0x1004, byteen 1111, mem_wdata 0xDEADBEEF; resp_valid at cycle 2, resp_rdata 0.
- SB addr 0x1003, wdata 0x000000A5 -> byteen 1000, mem_wdata 0xA5A5A5A5, mem_write high for exactly one cycle.
- LB addr 0x1002 with mem_rdata 0x12F03456 -> resp_rdata 0xFFFFFFF0; LBU at the same address -> 0x000000F0; LHU addr 0x1002 -> 0x000012F0; all at cycle 3.
- LW addr 0x1001 -> resp_misaligned = 1 at cycle 1, no mem_read. SH funct3 011 -> resp_illegal = 1 with misaligned = 0.
- resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable, req_ready = 0; the next request is accepted on the cycle after resp_ready.
- rst asserted mid-cycle during a store's ACCESS -> mem_write drops immediately, no response, req_ready = 1 after reset release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32I width/sign codes and FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package load_store_unit_pkg;

    localparam int LSU_XLEN = 32;

    // RV32I funct3 width/sign codes for loads and stores
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store replication, load extraction, legality/alignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic                we,
    input  logic [2:0]          funct3,
    input  logic [1:0]          addr,
    input  logic [LSU_XLEN-1:0] wdata,
    input  logic [LSU_XLEN-1:0] rdata,
    output logic [3:0]          byteen,
    output logic [LSU_XLEN-1:0] wdata_rep,
    output logic [LSU_XLEN-1:0] rdata_ext,
    output logic                misaligned,
    output logic                illegal
);

    logic [LSU_XLEN-1:0] rd_shift;
    logic [15:0]         rd_half;

    // Decode the access size, then steer lanes and flag bad requests; illegal masks misaligned
    always_comb begin
        byteen     = 4'b0000;
        wdata_rep  = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        rd_shift   = rdata >> {addr, 3'b000};
        rd_half    = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LSU_B, LSU_BU: begin
                byteen    = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (funct3 == LSU_B) ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                              : {24'h000000, rd_shift[7:0]};
                illegal   = we && (funct3 == LSU_BU);
            end
            LSU_H, LSU_HU: begin
                byteen     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = (funct3 == LSU_H) ? {{16{rd_half[15]}}, rd_half}
                                               : {16'h0000, rd_half};
                misaligned = addr[0];
                illegal    = we && (funct3 == LSU_HU);
            end
            LSU_W: begin
                byteen     = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = rdata;
                misaligned = (addr != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one request per transaction, word-aligned bus cycles.
// Latency: accept->resp_valid is 1 cycle (fault), 2 (store), 3 (load).
// Backpressure: req_ready only in IDLE; resp_valid held with stable outputs until resp_ready.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_misaligned,
    output logic             resp_illegal,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_byteen,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t state, next_state;

    logic             we_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic             mis_q;
    logic             ill_q;

    logic             in_idle;
    logic             accept;
    logic             al_we;
    logic [2:0]       al_funct3;
    logic [1:0]       al_addr;
    logic [WIDTH-1:0] al_wdata;
    logic [3:0]       al_byteen;
    logic [WIDTH-1:0] al_wdata_rep;
    logic [WIDTH-1:0] al_rdata_ext;
    logic             al_mis;
    logic             al_ill;

    assign in_idle = (state == ST_IDLE);
    assign accept  = in_idle && req_valid;

    // The aligner checks the live request while idle and steers the latched one afterwards
    assign al_we     = in_idle ? req_we        : we_q;
    assign al_funct3 = in_idle ? req_funct3    : funct3_q;
    assign al_addr   = in_idle ? req_addr[1:0] : addr_q[1:0];
    assign al_wdata  = in_idle ? req_wdata     : wdata_q;

    lsu_align u_align (
        .we         (al_we),
        .funct3     (al_funct3),
        .addr       (al_addr),
        .wdata      (al_wdata),
        .rdata      (mem_rdata),
        .byteen     (al_byteen),
        .wdata_rep  (al_wdata_rep),
        .rdata_ext  (al_rdata_ext),
        .misaligned (al_mis),
        .illegal    (al_ill)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the request and its fault flags on accept; capture extended load data at the end of WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            mis_q    <= al_mis;
            ill_q    <= al_ill;
        end else if (state == ST_WAIT) begin
            rdata_q  <= al_rdata_ext;
        end
    end

    // Next state and all outputs; bus strobes decode from state so reset drops them at once
    always_comb begin
        next_state      = state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_misaligned = 1'b0;
        resp_illegal    = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_byteen      = 4'b0000;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = (al_ill || al_mis) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr   = {addr_q[WIDTH-1:2], 2'b00};
                mem_wdata  = al_wdata_rep;
                mem_byteen = al_byteen;
                if (we_q) begin
                    mem_write  = 1'b1;
                    next_state = ST_RESP;
                end else begin
                    mem_read   = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_read   = 1'b1;
                mem_addr   = {addr_q[WIDTH-1:2], 2'b00};
                mem_wdata  = al_wdata_rep;
                mem_byteen = al_byteen;
                next_state = ST_RESP;
            end
            ST_RESP: begin
                resp_valid      = 1'b1;
                resp_rdata      = rdata_q;
                resp_misaligned = mis_q;
                resp_illegal    = ill_q;
                if (resp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule
